// File: rtl/demux_2x8_buf.sv
// rtl/demux_2x8_buf.sv - key-selected 1:4 demultiplexer with a single-entry buffer per channel
module demux_2x8_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_key,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       accept_cnt,
  output logic             busy
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [7:0]       cnt_q;
  logic             in_xfer;
  logic [3:0]       load;
  logic [3:0]       out_xfer;

  // A full channel still accepts when its consumer drains it on the same edge.
  assign in_ready = !valid_q[in_key] | out_ready[in_key];
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    load     = '0;
    out_xfer = valid_q & out_ready;
    if (in_xfer) begin
      load[in_key] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // A load wins over a drain so pass-through keeps the channel valid.
        if (load[i]) begin
          data_q[i]  <= in_data;
          valid_q[i] <= 1'b1;
        end else if (out_xfer[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (in_xfer) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign out1       = data_q[0];
  assign out2       = data_q[1];
  assign out3       = data_q[2];
  assign out4       = data_q[3];
  assign out_valid  = valid_q;
  assign accept_cnt = cnt_q;
  assign busy       = |valid_q;

endmodule

// File: tb/tb_demux_2x8_buf.sv
// tb/tb_demux_2x8_buf.sv - directed vector bench for demux_2x8_buf
module tb_demux_2x8_buf;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic [1:0] in_key;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1, out2, out3, out4;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] accept_cnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  demux_2x8_buf #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_key     (in_key),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [1:0] k;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov;
    logic [7:0] o1, o2, o3, o4;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample in_ready before the rising edge,
  // then leave the caller 1ns after the rising edge to check registered state.
  task automatic step(input logic v, input logic [1:0] k, input logic [7:0] d,
                      input logic [3:0] ordy, output logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_key    = k;
    in_data   = d;
    out_ready = ordy;
    #1 rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ov, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [7:0] o3, input logic [7:0] o4,
                           input logic [7:0] cnt);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".busy"}, 32'(busy), 32'(|ov));
    chk({tag, ".out1"}, 32'(out1), 32'(o1));
    chk({tag, ".out2"}, 32'(out2), 32'(o2));
    chk({tag, ".out3"}, 32'(out3), 32'(o3));
    chk({tag, ".out4"}, 32'(out4), 32'(o4));
    chk({tag, ".accept_cnt"}, 32'(accept_cnt), 32'(cnt));
  endtask

  initial begin
    logic rdy;
    int   stalls;
    int   bad;

    //          v     k     d      ordy      rdy   ov       o1     o2     o3     o4     cnt
    tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 8'd1};
    tbl[1]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0101, 8'h11, 8'h00, 8'hA5, 8'h00, 8'd2};
    tbl[2]  = '{1'b1, 2'd0, 8'h22, 4'b0000, 1'b0, 4'b0101, 8'h11, 8'h00, 8'hA5, 8'h00, 8'd2};
    tbl[3]  = '{1'b0, 2'd0, 8'hFF, 4'b0000, 1'b0, 4'b0101, 8'h11, 8'h00, 8'hA5, 8'h00, 8'd2};
    tbl[4]  = '{1'b1, 2'd1, 8'h33, 4'b0000, 1'b1, 4'b0111, 8'h11, 8'h33, 8'hA5, 8'h00, 8'd3};
    tbl[5]  = '{1'b1, 2'd1, 8'h44, 4'b0010, 1'b1, 4'b0111, 8'h11, 8'h44, 8'hA5, 8'h00, 8'd4};
    tbl[6]  = '{1'b0, 2'd3, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h11, 8'h44, 8'hA5, 8'h00, 8'd4};
    tbl[7]  = '{1'b0, 2'd0, 8'h77, 4'b0001, 1'b1, 4'b0000, 8'h11, 8'h44, 8'hA5, 8'h00, 8'd4};
    tbl[8]  = '{1'b1, 2'd0, 8'h01, 4'b0000, 1'b1, 4'b0001, 8'h01, 8'h44, 8'hA5, 8'h00, 8'd5};
    tbl[9]  = '{1'b1, 2'd1, 8'h02, 4'b0000, 1'b1, 4'b0011, 8'h01, 8'h02, 8'hA5, 8'h00, 8'd6};
    tbl[10] = '{1'b1, 2'd2, 8'h03, 4'b0000, 1'b1, 4'b0111, 8'h01, 8'h02, 8'h03, 8'h00, 8'd7};
    tbl[11] = '{1'b1, 2'd3, 8'h04, 4'b0000, 1'b1, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 8'd8};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h01, 8'h02, 8'h03, 8'h04, 8'd8};
    tbl[13] = '{1'b1, 2'd3, 8'h55, 4'b1000, 1'b1, 4'b1000, 8'h01, 8'h02, 8'h03, 8'h55, 8'd9};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_key    = 2'd0;
    in_data   = 8'h00;
    out_ready = 4'b0000;

    // Reset is observed before any clock edge has occurred.
    #2;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk_state("reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].k, tbl[i].d, tbl[i].ordy, rdy);
      chk($sformatf("vec%0d.in_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      chk_state($sformatf("vec%0d", i), tbl[i].ov, tbl[i].o1, tbl[i].o2,
                tbl[i].o3, tbl[i].o4, tbl[i].cnt);
    end

    // 256-word stream into channel 3 with the consumer always ready.
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    stalls = 0;
    bad    = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'd3, 8'(i), 4'b1000, rdy);
      if (rdy !== 1'b1) stalls++;
      if (out_valid !== 4'b1000 || out4 !== 8'(i)) bad++;
    end
    chk("stream.stalls", 32'(stalls), 32'd0);
    chk("stream.bad_cycles", 32'(bad), 32'd0);
    chk("stream.accept_cnt_wrap", 32'(accept_cnt), 32'd0);
    step(1'b0, 2'd3, 8'h00, 4'b1000, rdy);
    chk_state("stream_drain", 4'b0000, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd0);

    // Mid-cycle reset with channels 0 and 2 full.
    step(1'b1, 2'd0, 8'hC0, 4'b0000, rdy);
    step(1'b1, 2'd2, 8'hC2, 4'b0000, rdy);
    chk_state("prefill", 4'b0101, 8'hC0, 8'h00, 8'hC2, 8'hFF, 8'd2);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midreset.in_ready", 32'(in_ready), 32'd1);
    chk_state("midreset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 2'd1, 8'h9C, 4'b0000, rdy);
    chk("post_reset.in_ready", 32'(rdy), 32'd1);
    chk_state("post_reset", 4'b0010, 8'h00, 8'h9C, 8'h00, 8'h00, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
